// File: rtl/bp_core_cache_req_arb.sv
// bp_core_cache_req_arb: merges icache/dcache miss requests into one
// credited memory request stream with metadata join and round-robin grant.
module bp_core_cache_req_arb #(
   parameter int req_width_p      = 128,
   parameter int metadata_width_p = 4,
   parameter int credits_p        = 4
) (
   input  logic                                   clk_i,
   input  logic                                   reset_n_i,
   input  logic [2*req_width_p-1:0]               cache_req_i,
   input  logic [1:0]                             cache_req_v_i,
   output logic [1:0]                             cache_req_ready_o,
   input  logic [2*metadata_width_p-1:0]          cache_req_metadata_i,
   input  logic [1:0]                             cache_req_metadata_v_i,
   output logic [1:0]                             cache_req_complete_o,
   output logic [req_width_p+metadata_width_p:0]  mem_req_o,
   output logic                                   mem_req_v_o,
   input  logic                                   mem_req_ready_i,
   input  logic                                   mem_credit_return_i,
   input  logic                                   mem_done_v_i,
   input  logic                                   mem_done_port_i,
   output logic                                   credits_full_o,
   output logic                                   credits_empty_o
);

   localparam int cw_lp = $clog2(credits_p + 1);

   typedef enum logic [1:0] {IDLE, WAIT_MD, PEND, BUSY} state_e;

   state_e                      state_q [2];
   state_e                      state_n [2];
   logic [req_width_p-1:0]      req_q   [2];
   logic [metadata_width_p-1:0] md_q    [2];
   logic [1:0]                  pend;
   logic [1:0]                  done_hit;
   logic [1:0]                  complete_q;
   logic [cw_lp-1:0]            credit_q;
   logic                        full;
   logic                        empty;
   logic                        hs;
   logic                        grant;
   logic                        rr_q;
   logic                        lock_v_q;
   logic                        lock_id_q;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q[0] <= IDLE;
         state_q[1] <= IDLE;
      end else begin
         state_q <= state_n;
      end
   end

   always_comb begin
      state_n = state_q;
      for (int p = 0; p < 2; p++) begin
         unique case (state_q[p])
            IDLE:    if (cache_req_v_i[p]) state_n[p] = WAIT_MD;
            WAIT_MD: if (cache_req_metadata_v_i[p]) state_n[p] = PEND;
            PEND:    if (hs && grant == 1'(p)) state_n[p] = BUSY;
            BUSY:    if (done_hit[p]) state_n[p] = IDLE;
            default: state_n[p] = IDLE;
         endcase
      end
   end

   always_comb begin
      cache_req_ready_o = '0;
      pend              = '0;
      done_hit          = '0;
      for (int p = 0; p < 2; p++) begin
         cache_req_ready_o[p] = (state_q[p] == IDLE);
         pend[p]              = (state_q[p] == PEND);
         done_hit[p]          = (state_q[p] == BUSY) && mem_done_v_i
                                && (mem_done_port_i == 1'(p));
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         req_q[0] <= '0;
         req_q[1] <= '0;
         md_q[0]  <= '0;
         md_q[1]  <= '0;
      end else begin
         for (int p = 0; p < 2; p++) begin
            if (state_q[p] == IDLE && cache_req_v_i[p])
               req_q[p] <= cache_req_i[p*req_width_p +: req_width_p];
            if (state_q[p] == WAIT_MD && cache_req_metadata_v_i[p])
               md_q[p] <= cache_req_metadata_i[p*metadata_width_p +: metadata_width_p];
         end
      end
   end

   assign full        = (credit_q == cw_lp'(credits_p));
   assign empty       = (credit_q == '0);
   assign mem_req_v_o = (|pend) & ~full;
   assign hs          = mem_req_v_o & mem_req_ready_i;

   // A stalled offer keeps its port even if the other port becomes eligible.
   always_comb begin
      if (lock_v_q)          grant = lock_id_q;
      else if (pend == 2'b11) grant = ~rr_q;
      else                    grant = pend[1];
   end

   assign mem_req_o = {grant, md_q[grant], req_q[grant]};

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         lock_v_q  <= 1'b0;
         lock_id_q <= 1'b0;
         rr_q      <= 1'b1;
      end else begin
         lock_v_q <= mem_req_v_o & ~mem_req_ready_i;
         if (mem_req_v_o) lock_id_q <= grant;
         if (hs)          rr_q      <= grant;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         credit_q <= '0;
      end else begin
         unique case ({hs, mem_credit_return_i})
            2'b10:   credit_q <= credit_q + cw_lp'(1);
            2'b01:   if (!empty) credit_q <= credit_q - cw_lp'(1);
            default: credit_q <= credit_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) complete_q <= '0;
      else            complete_q <= done_hit;
   end

   assign cache_req_complete_o = complete_q;
   assign credits_full_o       = full;
   assign credits_empty_o      = empty;

   a_credit_underflow: assert property (
      @(posedge clk_i) disable iff (!reset_n_i)
      !(mem_credit_return_i && !hs && empty))
      else $warning("credit return with no credits outstanding");

endmodule

// File: tb/tb_bp_core_cache_req_arb.sv
// Bench for bp_core_cache_req_arb: transaction-level model checked
// every cycle plus directed literal expectations.
module tb_bp_core_cache_req_arb;

   localparam int RW = 128;
   localparam int MW = 4;
   localparam int CP = 4;
   localparam int OW = RW + MW + 1;

   logic            clk   = 1'b0;
   logic            rst_n = 1'b1;
   logic [2*RW-1:0] req   = '0;
   logic [1:0]      req_v = '0;
   logic [1:0]      rdy;
   logic [2*MW-1:0] md    = '0;
   logic [1:0]      md_v  = '0;
   logic [1:0]      cmpl;
   logic [OW-1:0]   mreq;
   logic            mv;
   logic            mrdy  = 1'b1;
   logic            cret  = 1'b0;
   logic            dv    = 1'b0;
   logic            dport = 1'b0;
   logic            full;
   logic            empty;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bp_core_cache_req_arb #(
      .req_width_p(RW), .metadata_width_p(MW), .credits_p(CP)
   ) dut (
      .clk_i(clk), .reset_n_i(rst_n),
      .cache_req_i(req), .cache_req_v_i(req_v),
      .cache_req_ready_o(rdy),
      .cache_req_metadata_i(md), .cache_req_metadata_v_i(md_v),
      .cache_req_complete_o(cmpl),
      .mem_req_o(mreq), .mem_req_v_o(mv), .mem_req_ready_i(mrdy),
      .mem_credit_return_i(cret),
      .mem_done_v_i(dv), .mem_done_port_i(dport),
      .credits_full_o(full), .credits_empty_o(empty)
   );

   // Model: per port "holds request", "has metadata", "sent downstream".
   typedef struct {
      logic [1:0]          req;
      logic [1:0]          md;
      logic [1:0]          fly;
      logic [1:0]          cmpl;
      logic [1:0][RW-1:0]  rd;
      logic [1:0][MW-1:0]  mdd;
      int                  cred;
      int                  last;
      int                  lock;
   } mst_t;

   mst_t m;

   function automatic mst_t m_reset();
      mst_t s;
      s.req = '0; s.md = '0; s.fly = '0; s.cmpl = '0;
      s.rd = '0; s.mdd = '0;
      s.cred = 0; s.last = 1; s.lock = -1;
      return s;
   endfunction

   function automatic bit m_pend(input mst_t s, input int p);
      return s.req[p] && s.md[p] && !s.fly[p];
   endfunction

   function automatic bit m_v(input mst_t s);
      return (m_pend(s, 0) || m_pend(s, 1)) && (s.cred < CP);
   endfunction

   function automatic int m_win(input mst_t s);
      if (s.lock >= 0) return s.lock;
      if (m_pend(s, 0) && m_pend(s, 1)) return 1 - s.last;
      return m_pend(s, 1) ? 1 : 0;
   endfunction

   function automatic logic [OW-1:0] m_out(input mst_t s);
      int w;
      w = m_win(s);
      return {w[0], s.mdd[w], s.rd[w]};
   endfunction

   function automatic mst_t m_next(input mst_t s);
      mst_t n;
      bit   v;
      bit   hs;
      int   w;
      n  = s;
      v  = m_v(s);
      w  = m_win(s);
      hs = v && mrdy;
      n.cmpl = '0;
      for (int p = 0; p < 2; p++) begin
         if (!s.req[p]) begin
            if (req_v[p]) begin
               n.req[p] = 1'b1;
               n.rd[p]  = req[p*RW +: RW];
            end
         end else if (!s.md[p]) begin
            if (md_v[p]) begin
               n.md[p]  = 1'b1;
               n.mdd[p] = md[p*MW +: MW];
            end
         end else if (!s.fly[p]) begin
            if (hs && w == p) n.fly[p] = 1'b1;
         end else if (dv && dport == p[0]) begin
            n.req[p] = 1'b0; n.md[p] = 1'b0; n.fly[p] = 1'b0;
            n.cmpl[p] = 1'b1;
         end
      end
      if (hs) begin
         n.last = w; n.lock = -1; n.cred = s.cred + 1;
      end else if (v) begin
         n.lock = w;
      end
      if (cret && n.cred > 0 && (hs || s.cred > 0)) n.cred = n.cred - 1;
      return n;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m <= m_reset();
      else        m <= m_next(m);
   end

   task automatic chk(input string nm, input logic [OW-1:0] act,
                      input logic [OW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin : cmp
      logic [1:0] e_rdy;
      e_rdy = ~m.req;
      chk("ready", rdy, e_rdy);
      chk("complete", cmpl, m.cmpl);
      chk("mem_v", mv, m_v(m));
      chk("full", full, m.cred == CP);
      chk("empty", empty, m.cred == 0);
      if (m_v(m)) chk("mem_req", mreq, m_out(m));
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic issue(input int p);
      req[p*RW +: RW] = {4{32'hC0DE_0000 + 32'(p)}};
      md[p*MW +: MW]  = 4'(p + 3);
      req_v[p] = 1'b1; step(); req_v = '0;
      md_v[p]  = 1'b1; step(); md_v  = '0;
      step();
      dv = 1'b1; dport = p[0]; step(); dv = 1'b0;
   endtask

   initial begin
      #1 rst_n = 1'b0;
      @(negedge clk);
      chk("rst_ready", rdy, 2'b11);
      chk("rst_v", mv, 1'b0);
      chk("rst_full", full, 1'b0);
      chk("rst_empty", empty, 1'b1);
      chk("rst_cmpl", cmpl, 2'b00);
      rst_n = 1'b1;
      step();

      // single dcache request
      req[RW +: RW] = {4{32'hDCAC_0001}};
      req_v = 2'b10; step(); req_v = '0;
      md[MW +: MW] = 4'hB; md_v = 2'b10; step(); md_v = '0;
      chk("t1_v_c2", mv, 1'b1);
      chk("t1_port", mreq[OW-1], 1'b1);
      chk("t1_md", mreq[RW +: MW], 4'hB);
      step(); step(); step();
      dv = 1'b1; dport = 1'b1; step(); dv = 1'b0;
      chk("t1_cmpl_c6", cmpl, 2'b10);
      chk("t1_rdy_c6", rdy[1], 1'b1);
      step();
      chk("t1_cmpl_c7", cmpl, 2'b00);
      cret = 1'b1; step(); cret = 1'b0;
      chk("t1_empty", empty, 1'b1);

      // ties alternate 0 then 1 each round
      for (int r = 0; r < 2; r++) begin
         req = {{4{32'h1111_0000 + 32'(r)}}, {4{32'h0000_1110 + 32'(r)}}};
         md  = 8'h5A;
         req_v = 2'b11; step(); req_v = '0;
         md_v  = 2'b11; step(); md_v  = '0;
         chk("tie_first", mreq[OW-1], 1'b0);
         step();
         chk("tie_second", mreq[OW-1], 1'b1);
         step();
         dv = 1'b1; dport = 1'b0; step();
         dport = 1'b1; step(); dv = 1'b0;
         cret = 1'b1; step(); step(); cret = 1'b0;
      end

      // credit exhaustion and recovery
      issue(0); issue(1); issue(0); issue(1);
      chk("cr_full", full, 1'b1);
      req[RW-1:0] = {4{32'hF00D_0005}};
      req_v = 2'b01; step(); req_v = '0;
      md_v  = 2'b01; step(); md_v  = '0;
      chk("cr_block", mv, 1'b0);
      step();
      chk("cr_block2", mv, 1'b0);
      cret = 1'b1; step(); cret = 1'b0;
      chk("cr_reopen", mv, 1'b1);
      chk("cr_notfull", full, 1'b0);
      step();
      chk("cr_full2", full, 1'b1);
      dv = 1'b1; dport = 1'b0; step(); dv = 1'b0;
      cret = 1'b1; repeat (4) step(); cret = 1'b0;
      chk("cr_drained", empty, 1'b1);

      // stalled downstream keeps port 0 offered
      mrdy = 1'b0;
      req = {{4{32'hBBBB_0001}}, {4{32'hAAAA_0001}}};
      md  = 8'h21;
      req_v = 2'b01; step();
      req_v = 2'b10; md_v = 2'b01; step();
      req_v = '0; md_v = 2'b10; step(); md_v = '0;
      for (int i = 0; i < 5; i++) begin
         chk("stall_v", mv, 1'b1);
         chk("stall_port", mreq[OW-1], 1'b0);
         step();
      end
      mrdy = 1'b1;
      chk("stall_first", mreq[OW-1], 1'b0);
      step();
      chk("stall_second", mreq[OW-1], 1'b1);
      step();
      dv = 1'b1; dport = 1'b0; step();
      dport = 1'b1; step(); dv = 1'b0;
      cret = 1'b1; step(); step(); cret = 1'b0;

      // stray done, stray metadata, credit underflow
      dv = 1'b1; dport = 1'b0; md_v = 2'b01; step();
      dv = 1'b0; md_v = '0; step();
      chk("stray_cmpl", cmpl, 2'b00);
      chk("stray_rdy", rdy, 2'b11);
      cret = 1'b1; step(); cret = 1'b0;
      chk("under_empty", empty, 1'b1);
      chk("under_full", full, 1'b0);
      req[RW-1:0] = {4{32'h5151_0001}};
      req_v = 2'b01; md_v = 2'b01; step();
      req_v = '0; md_v = '0; step();
      chk("same_md_ignored", mv, 1'b0);
      md_v = 2'b01; step(); md_v = '0;
      chk("late_md_v", mv, 1'b1);
      step();
      dv = 1'b1; dport = 1'b0; step(); dv = 1'b0;
      cret = 1'b1; step(); cret = 1'b0;

      // reset while port 1 busy with two credits out
      issue(0);
      req[RW +: RW] = {4{32'h7777_0001}};
      req_v = 2'b10; step(); req_v = '0;
      md_v  = 2'b10; step(); md_v  = '0;
      step();
      chk("pre_rst_empty", empty, 1'b0);
      chk("pre_rst_rdy", rdy, 2'b01);
      #3 rst_n = 1'b0;
      #1;
      chk("mid_rst_rdy", rdy, 2'b11);
      chk("mid_rst_v", mv, 1'b0);
      chk("mid_rst_empty", empty, 1'b1);
      chk("mid_rst_full", full, 1'b0);
      chk("mid_rst_cmpl", cmpl, 2'b00);
      @(negedge clk);
      rst_n = 1'b1;
      dv = 1'b1; dport = 1'b1; step(); dv = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("post_rst_cmpl", cmpl, 2'b00);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bp_core_cache_req_arb.md
Name: bp_core_cache_req_arb

Overview:
- Sits directly downstream of the core's two cache-miss request channels: port 0 is icache, port 1 is dcache.
- Merges the two channels into a single memory-side request stream.
- Per port: captures the request, waits for its late-arriving metadata, then round-robin arbitrates onto one credited downstream channel.
- Returns a one-cycle cache_req_complete pulse to the originating port and drives credits_full/credits_empty back to the core.

Parameters:
- req_width_p, 128, width of one cache request packet
- metadata_width_p, 4, width of one request metadata packet
- credits_p, 4, maximum downstream requests in flight (credit pool size, ≥1)

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  reset, asynchronous, active-low
- cache_req_i  in  2*req_width_p  per-port request packet
- cache_req_v_i  in  2  per-port request valid
- cache_req_ready_o  out  2  per-port request ready
- cache_req_metadata_i  in  2*metadata_width_p  per-port metadata
- cache_req_metadata_v_i  in  2  per-port metadata valid
- cache_req_complete_o  out  2  per-port completion pulse
- mem_req_o  out  req_width_p+metadata_width_p+1  {port_id, metadata, request}; port_id is the MSB
- mem_req_v_o  out  1  downstream valid
- mem_req_ready_i  in  1  downstream ready
- mem_credit_return_i  in  1  one credit returned
- mem_done_v_i  in  1  downstream completion valid
- mem_done_port_i  in  1  port id of the completion
- credits_full_o  out  1  credit counter == credits_p
- credits_empty_o  out  1  credit counter == 0

Behaviour:
- Reset (reset_n_i low, asynchronous assert, synchronous release):
  - both port FSMs go to IDLE; credit count = 0; round-robin pointer = 1 (so port 0 wins the first tie).
  - Outputs during reset: cache_req_ready_o=2'b11, cache_req_complete_o=0, mem_req_v_o=0, credits_full_o=0, credits_empty_o=1.
  - Reset mid-operation discards all captured requests; no completion pulses are issued for them.
- Per-port FSM with states IDLE, WAIT_MD, PEND, BUSY:
  - IDLE: ready_o=1. On v_i=1, capture the request and move to WAIT_MD.
  - WAIT_MD: ready_o=0. On metadata_v_i=1, capture the metadata and move to PEND. metadata_v_i in IDLE, or in the same cycle the request is captured, is ignored.
  - PEND: the port is eligible for arbitration. When granted and the mem_req handshake completes, move to BUSY.
  - BUSY: wait for mem_done_v_i=1 with mem_done_port_i == port. Then move to IDLE and assert cache_req_complete_o[port] for exactly one cycle, in the cycle after the done is sampled (registered).
- Completion rules:
  - mem_done_v_i for a port not in BUSY is ignored.
  - The port returns to IDLE in the same edge the done is sampled, so ready_o=1 while complete_o is pulsing. A new request may be accepted in that cycle.
- Arbitration and downstream output:
  - mem_req_v_o = (any port in PEND) & ~credits_full.
  - Winner: the only PEND port, or on a tie the port not equal to the pointer. The pointer updates to the winner on each handshake (mem_req_v_o & mem_req_ready_i).
  - Once mem_req_v_o rises, the grant is locked and mem_req_o is held stable until the handshake. Ready may be low for any number of cycles.
  - mem_req_v_o may depend combinationally on registered state only. It must not depend on mem_req_ready_i.
- Latency (no contention, credits available):
  - request accepted at cycle 0, metadata at cycle 1 → PEND at cycle 2 → mem_req_v_o=1 at cycle 2.
- Credit counter, width clog2(credits_p+1):
  - +1 on handshake, −1 on mem_credit_return_i; both in the same cycle → unchanged.
  - A return while count==0 is an error: count holds at 0 and a simulation assertion fires.
  - A handshake while full cannot occur, because v is gated by full.
  - credits_full_o and credits_empty_o are decoded from the registered count.
- Simultaneous events:
  - Done for one port and a grant for the other port in the same cycle are both honoured.
  - A credit return while full re-enables mem_req_v_o in the next cycle.

Test Plan:
- Single dcache request (v_i[1] at c0, metadata_v_i[1] at c1, mem_req_ready_i=1) → mem_req_v_o=1 at c2 with MSB=1; mem_done_v_i port 1 at c5 → cache_req_complete_o=2'b10 at c6 only; cache_req_ready_o[1]=1 at c6.
- Both ports reach PEND in the same cycle after reset → port 0 is issued first, then port 1 on the next handshake. Repeat ties → grants alternate 0,1,0,1.
- credits_p=4: issue 4 requests with no returns → credits_full_o=1 and mem_req_v_o=0 with a PEND port waiting. One mem_credit_return_i → count 3, mem_req_v_o=1 next cycle.
- mem_req_ready_i low for 5 cycles while port 0 is PEND and port 1 becomes PEND → mem_req_o is unchanged (still port 0) until ready; port 0 issued first.
- mem_done_v_i for port 0 while port 0 is IDLE → no complete pulse, no state change. Credit return at count 0 → count stays 0 and the assertion fires.
- reset_n_i asserted mid-cycle while port 1 is BUSY and count=2 → outputs immediately take reset values; no cache_req_complete_o after reset is released.
